// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: sequential restoring divider, 2W-bit dividend by W-bit divisor, one bit per cycle.
// Optional `exact` output (legal W x W product check) enabled by defining DIV_EXACT_CHECK_EN.
module seq_restoring_divider #(
    parameter int W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   quotient,
    output logic [W-1:0]     remainder,
`ifdef DIV_EXACT_CHECK_EN
    output logic             exact,
`endif
    output logic             div_zero
);
    localparam int CW = (2 * W > 1) ? $clog2(2 * W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  dvd_q, dvd_d, acc_q, acc_d, quo_q, quo_d;
    logic [W-1:0]    dvs_q, dvs_d, rmd_q, rmd_d;
    logic [W:0]      rem_q, rem_d, rem_sh;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d, dz_q, dz_d, ge, zero;
`ifdef DIV_EXACT_CHECK_EN
    logic            exact_q, exact_d;
    assign exact = exact_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rmd_d       = rmd_q;
        dz_d        = dz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef DIV_EXACT_CHECK_EN
        exact_d     = exact_q;
`endif
        rem_sh      = {rem_q[W-1:0], dvd_q[2*W-1]};
        ge          = rem_sh >= {1'b0, dvs_q};
        zero        = dvs_q == '0;
        case (state_q)
            IDLE: if (in_valid) begin
                dvd_d      = dividend;
                dvs_d      = divisor;
                rem_d      = '0;
                acc_d      = '0;
                cnt_d      = CW'(2 * W - 1);
                dz_d       = 1'b0;
                in_ready_d = 1'b0;
                state_d    = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                dvd_d   = dvd_q << 1;
                rem_d   = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
                acc_d   = {acc_q[2*W-2:0], ge};
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? DONE : CALC;
            end
            DONE: if (!out_valid_q) begin
                // Results are published one cycle after entering DONE so they are registered.
                out_valid_d = 1'b1;
                quo_d       = zero ? '1 : acc_q;
                rmd_d       = zero ? dvd_q[W-1:0] : rem_q[W-1:0];
                dz_d        = zero;
`ifdef DIV_EXACT_CHECK_EN
                exact_d     = !zero && rem_q == '0 && acc_q[2*W-1:W] == '0;
`endif
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            quo_q       <= '0;
            rmd_q       <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DIV_EXACT_CHECK_EN
            exact_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rmd_q       <= rmd_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef DIV_EXACT_CHECK_EN
            exact_q     <= exact_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed vectors for seq_restoring_divider with W=2.
// Checks latency, results, divide-by-zero, back-pressure and asynchronous reset abort.
module tb_seq_restoring_divider;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] dividend = '0;
    logic [1:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       div_zero;
`ifdef DIV_EXACT_CHECK_EN
    logic       exact;
`endif
    int total = 0;
    int bad = 0;

    seq_restoring_divider #(.W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
`ifdef DIV_EXACT_CHECK_EN
        .exact(exact),
`endif
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] a, input logic [1:0] b, input logic [3:0] eq,
                          input logic [1:0] er, input logic edz, input int elat, input logic eex);
        int k;
        @(negedge clk);
        chk("idle_rdy", in_ready, 1);
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, elat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_zero", div_zero, edz);
        chk("busy_rdy", in_ready, 0);
`ifdef DIV_EXACT_CHECK_EN
        chk("exact", exact, eex);
`else
        if (eex !== 1'bx) k = 0;
`endif
        @(negedge clk);
        chk("ov_drop", out_valid, 0);
        chk("rdy_back", in_ready, 1);
    endtask

    initial begin
        int k;
        int pulses;
        #12;
        chk("rst_ov", out_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd6, 2'd2, 4'd3, 2'd0, 1'b0, 5, 1'b1);
        run_op(4'd9, 2'd3, 4'd3, 2'd0, 1'b0, 5, 1'b1);
        run_op(4'd7, 2'd2, 4'd3, 2'd1, 1'b0, 5, 1'b0);
        run_op(4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 5, 1'b0);
        run_op(4'd13, 2'd0, 4'd15, 2'd1, 1'b1, 1, 1'b0);
        run_op(4'd15, 2'd3, 4'd5, 2'd0, 1'b0, 5, 1'b0);
        run_op(4'd0, 2'd3, 4'd0, 2'd0, 1'b0, 5, 1'b1);
        // Back-pressure: result must hold while out_ready is low; busy inputs are ignored.
        @(negedge clk);
        dividend = 4'd7;
        divisor = 2'd3;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp_latency", k, 5);
        for (int i = 0; i < 4; i++) begin
            in_valid = (i == 1);
            dividend = 4'd15;
            divisor = 2'd1;
            @(negedge clk);
            chk("bp_ov", out_valid, 1);
            chk("bp_q", quotient, 2);
            chk("bp_r", remainder, 1);
            chk("bp_rdy", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ov_drop", out_valid, 0);
        chk("bp_rdy_back", in_ready, 1);
        @(negedge clk);
        chk("bp_once", out_valid, 0);
        // Asynchronous reset in the middle of CALC aborts the operation.
        dividend = 4'd9;
        divisor = 2'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_rdy", in_ready, 1);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("arst_no_pulse", pulses, 0);
        run_op(4'd9, 2'd3, 4'd3, 2'd0, 1'b0, 5, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
